// File: rtl/trisc_pkg.sv
// Shared opcode values and sequencer state encoding for the trisc accumulator controller.
package trisc_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_CLR  = 4'h1;
  localparam logic [3:0] OP_LDA  = 4'h2;
  localparam logic [3:0] OP_LDB  = 4'h3;
  localparam logic [3:0] OP_INC  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_HALT = 4'h7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALTED
  } state_e;

  // Opcodes 8..F are undefined and run as NOP.
  function automatic logic op_illegal(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/trisc_pc.sv
// Program counter: clear has priority over load, load over increment; wraps mod 2^AW.
module trisc_pc #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic          load_i,
  input  logic [AW-1:0] load_val_i,
  output logic [AW-1:0] pc_o
);

  logic [AW-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (clr_i)       pc_d = '0;
    else if (load_i) pc_d = load_val_i;
    else if (inc_i)  pc_d = pc_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/trisc_ctrl.sv
// Three-state fetch/decode/exec sequencer driving the accumulator; AW must not exceed DW.
module trisc_ctrl
  import trisc_pkg::*;
#(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW+3:0] instr,
  input  logic [DW-1:0] acc_q,
  output logic [AW-1:0] pc_addr,
  output logic          acc_clear,
  output logic          acc_load,
  output logic          acc_inc,
  output logic          acc_ab,
  output logic [DW-1:0] acc_a,
  output logic          halted,
  output logic          illegal
);

  state_e        state_q;
  logic [DW+3:0] ir_q;
  logic          clear_q, load_q, inc_q, ab_q;
  logic          halted_q, illegal_q;

  logic [3:0] dec_op, ex_op;
  logic       pc_clr, pc_inc, pc_load;

  assign dec_op = instr[DW+3:DW];
  assign ex_op  = ir_q[DW+3:DW];

  // Branch outcome is resolved combinationally from acc_q while in EXEC.
  assign pc_clr  = (state_q == ST_HALTED) && start;
  assign pc_load = (state_q == ST_EXEC) &&
                   ((ex_op == OP_JMP) || ((ex_op == OP_JZ) && (acc_q == '0)));
  assign pc_inc  = (state_q == ST_EXEC) && !pc_load && (ex_op != OP_HALT);

  trisc_pc #(.AW(AW)) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (pc_clr),
    .inc_i      (pc_inc),
    .load_i     (pc_load),
    .load_val_i (ir_q[AW-1:0]),
    .pc_o       (pc_addr)
  );

  // Controls are decoded from ROM data in DECODE so they are registered high exactly in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      clear_q   <= 1'b0;
      load_q    <= 1'b0;
      inc_q     <= 1'b0;
      ab_q      <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      load_q  <= 1'b0;
      inc_q   <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) state_q <= ST_FETCH;
        ST_FETCH: state_q <= ST_DECODE;
        ST_DECODE: begin
          ir_q    <= instr;
          ab_q    <= (dec_op == OP_LDB);
          clear_q <= (dec_op == OP_CLR);
          load_q  <= (dec_op == OP_LDA) || (dec_op == OP_LDB);
          inc_q   <= (dec_op == OP_INC);
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (op_illegal(ex_op)) illegal_q <= 1'b1;
          if (ex_op == OP_HALT) begin
            halted_q <= 1'b1;
            state_q  <= ST_HALTED;
          end else begin
            state_q  <= ST_FETCH;
          end
        end
        ST_HALTED: begin
          if (start) begin
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            state_q   <= ST_FETCH;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign acc_clear = clear_q;
  assign acc_load  = load_q;
  assign acc_inc   = inc_q;
  assign acc_ab    = ab_q;
  assign acc_a     = ir_q[DW-1:0];
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_trisc_ctrl.sv
// Bench for trisc_ctrl: synchronous ROM, accumulator environment, vector table,
// corner-case sequences and an instruction-level reference model under random programs.
module tb_trisc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] instr = 8'h00;
  logic [3:0] acc_q;
  logic [3:0] pc_addr;
  logic       acc_clear, acc_load, acc_inc, acc_ab;
  logic [3:0] acc_a;
  logic       halted, illegal;

  logic [7:0] rom [16];
  logic [3:0] acc_reg = 4'h0;
  logic [3:0] ext_b = 4'h0;
  logic       force_en = 1'b0;
  logic [3:0] force_val = 4'h0;
  logic       acc_set = 1'b0;
  logic [3:0] acc_set_val = 4'h0;

  int n_checks = 0;
  int n_err = 0;

  trisc_ctrl #(.DW(4), .AW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .instr     (instr),
    .acc_q     (acc_q),
    .pc_addr   (pc_addr),
    .acc_clear (acc_clear),
    .acc_load  (acc_load),
    .acc_inc   (acc_inc),
    .acc_ab    (acc_ab),
    .acc_a     (acc_a),
    .halted    (halted),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) instr <= rom[pc_addr];

  always @(posedge clk) begin
    if (acc_set)        acc_reg <= acc_set_val;
    else if (acc_clear) acc_reg <= 4'h0;
    else if (acc_load)  acc_reg <= acc_ab ? ext_b : acc_a;
    else if (acc_inc)   acc_reg <= acc_reg + 4'h1;
  end

  assign acc_q = force_en ? force_val : acc_reg;

  typedef struct {
    logic [7:0] ins;
    logic [3:0] acc;
    logic       clr;
    logic       ld;
    logic       inc;
    logic [3:0] npc;
    logic       ill;
    logic       hlt;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Instruction-level reference: one ISA step per loop iteration, 3 cycles each.
  task automatic run_random(input int run);
    logic [3:0] m_pc, m_acc, op, opd, v;
    logic       m_ill, hlt;
    clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = {4'($urandom_range(0, 15)), 4'($urandom)};
    ext_b = 4'($urandom);
    force_en = 1'b0;
    do_reset();
    v = 4'($urandom_range(0, 3));
    acc_set_val = v;
    acc_set = 1'b1;
    tick();
    acc_set = 1'b0;
    m_pc = 4'h0;
    m_acc = v;
    m_ill = 1'b0;
    pulse_start();
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("rnd%0d_fetch_pc", run), 32'(pc_addr), 32'(m_pc));
      tick();
      tick();
      op  = rom[m_pc][7:4];
      opd = rom[m_pc][3:0];
      chk($sformatf("rnd%0d_ctrl", run), 32'({acc_clear, acc_load, acc_inc, acc_ab, acc_a}),
          32'({op == 4'h1, op == 4'h2 || op == 4'h3, op == 4'h4, op == 4'h3, opd}));
      hlt = (op == 4'h7);
      if (op >= 4'h8) m_ill = 1'b1;
      case (op)
        4'h5:    m_pc = opd;
        4'h6:    m_pc = (m_acc == 4'h0) ? opd : m_pc + 4'h1;
        4'h7:    m_pc = m_pc;
        default: m_pc = m_pc + 4'h1;
      endcase
      case (op)
        4'h1:    m_acc = 4'h0;
        4'h2:    m_acc = opd;
        4'h3:    m_acc = ext_b;
        4'h4:    m_acc = m_acc + 4'h1;
        default: m_acc = m_acc;
      endcase
      tick();
      chk($sformatf("rnd%0d_flags", run), 32'({illegal, halted}), 32'({m_ill, hlt}));
      if (hlt) begin
        chk($sformatf("rnd%0d_halt_pc", run), 32'(pc_addr), 32'(m_pc));
        chk($sformatf("rnd%0d_acc", run), 32'(acc_reg), 32'(m_acc));
        break;
      end
    end
  endtask

  initial begin
    logic [3:0] saved;
    clear_rom();

    vecs[0]  = '{8'h10, 4'h0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0};
    vecs[1]  = '{8'h25, 4'h0, 1'b0, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0};
    vecs[2]  = '{8'h37, 4'h0, 1'b0, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0};
    vecs[3]  = '{8'h40, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0};
    vecs[4]  = '{8'h5C, 4'h0, 1'b0, 1'b0, 1'b0, 4'hC, 1'b0, 1'b0};
    vecs[5]  = '{8'h6A, 4'h0, 1'b0, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0};
    vecs[6]  = '{8'h6A, 4'h3, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0};
    vecs[7]  = '{8'h70, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1};
    vecs[8]  = '{8'h9C, 4'h0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0};
    vecs[9]  = '{8'h00, 4'h5, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0};
    vecs[10] = '{8'hF3, 4'h0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0};
    vecs[11] = '{8'h5F, 4'h0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0};

    // Reset state and idle behaviour
    tick();
    #1;
    chk("reset_outputs", 32'({pc_addr, acc_clear, acc_load, acc_inc, acc_ab, acc_a, halted, illegal}), 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle_no_activity", 32'({pc_addr, acc_clear, acc_load, acc_inc}), 32'd0);
    end

    // Single-instruction vector table
    for (int i = 0; i < 12; i++) begin
      do_reset();
      clear_rom();
      rom[0] = vecs[i].ins;
      force_en = 1'b1;
      force_val = vecs[i].acc;
      pulse_start();
      tick();
      tick();
      chk($sformatf("vec%0d_ctrl", i), 32'({acc_clear, acc_load, acc_inc}),
          32'({vecs[i].clr, vecs[i].ld, vecs[i].inc}));
      chk($sformatf("vec%0d_operand", i), 32'({acc_ab, acc_a}),
          32'({vecs[i].ins[7:4] == 4'h3, vecs[i].ins[3:0]}));
      tick();
      chk($sformatf("vec%0d_next_pc", i), 32'(pc_addr), 32'(vecs[i].npc));
      chk($sformatf("vec%0d_flags", i), 32'({illegal, halted}), 32'({vecs[i].ill, vecs[i].hlt}));
    end
    force_en = 1'b0;

    // Basic program, cycle-exact
    do_reset();
    clear_rom();
    rom[0] = 8'h10; rom[1] = 8'h25; rom[2] = 8'h40; rom[3] = 8'h70;
    start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      start = 1'b0;
      chk($sformatf("basic_c%0d_ctrl", c), 32'({acc_clear, acc_load, acc_inc}),
          32'({c == 3, c == 6, c == 9}));
      if (c == 6) chk("basic_lda_operand", 32'({acc_ab, acc_a}), 32'({1'b0, 4'h5}));
      if (c <= 11) chk($sformatf("basic_c%0d_running", c), 32'(halted), 32'd0);
      if (c >= 13) chk($sformatf("basic_c%0d_halted", c), 32'({halted, pc_addr}), 32'({1'b1, 4'h3}));
    end

    // PC wrap-around with all NOPs
    do_reset();
    clear_rom();
    pulse_start();
    for (int k = 0; k <= 16; k++) begin
      chk($sformatf("wrap_k%0d_pc", k), 32'(pc_addr), 32'(k % 16));
      tick(); tick(); tick();
    end

    // Illegal opcode, recovery, restart from HALTED
    do_reset();
    clear_rom();
    rom[0] = 8'h9C; rom[1] = 8'h41; rom[2] = 8'h70;
    pulse_start();
    tick(); tick();
    chk("ill_no_ctrl", 32'({acc_clear, acc_load, acc_inc}), 32'd0);
    tick();
    chk("ill_flag_set", 32'({illegal, pc_addr}), 32'({1'b1, 4'h1}));
    tick(); tick();
    chk("ill_next_inc", 32'(acc_inc), 32'd1);
    tick(); tick(); tick(); tick();
    chk("ill_halted_sticky", 32'({halted, illegal, pc_addr}), 32'({1'b1, 1'b1, 4'h2}));
    tick();
    pulse_start();
    chk("ill_restart", 32'({halted, illegal, pc_addr}), 32'({1'b0, 1'b0, 4'h0}));

    // Reset asserted during EXEC of INC
    do_reset();
    clear_rom();
    rom[0] = 8'h00; rom[1] = 8'h40;
    pulse_start();
    for (int c = 2; c <= 6; c++) tick();
    chk("rst_exec_pre", 32'({acc_inc, pc_addr}), 32'({1'b1, 4'h1}));
    saved = acc_reg;
    rst_n = 1'b0;
    #1;
    chk("rst_exec_drop", 32'({acc_inc, pc_addr}), 32'({1'b0, 4'h0}));
    tick();
    chk("rst_exec_acc_kept", 32'(acc_reg), 32'(saved));
    rst_n = 1'b1;

    // start pulsed during DECODE is ignored
    do_reset();
    clear_rom();
    rom[0] = 8'h40; rom[1] = 8'h40; rom[2] = 8'h70;
    pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("dec_start_inc0", 32'(acc_inc), 32'd1);
    tick();
    chk("dec_start_pc1", 32'(pc_addr), 32'd1);
    tick(); tick();
    chk("dec_start_inc1", 32'(acc_inc), 32'd1);

    // Random programs against the instruction-level model
    for (int r = 0; r < 16; r++) run_random(r);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/trisc_ctrl.md
Name: trisc_ctrl

Overview:
Sequencer that sits directly upstream of the accumulator. It fetches 8-bit instructions from an external synchronous program ROM and decodes them. It drives the accumulator's clear/load/inc/AB controls and its immediate data input, and evaluates conditional jumps on the accumulator value fed back to it. Each instruction runs as a fixed three-state FETCH/DECODE/EXEC sequence.

Parameters:
DW, 4, accumulator/operand width; instruction width = 4+DW
AW, 4, program counter width; must satisfy AW <= DW, so a jump target fits in the operand field

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins execution from IDLE or HALTED
instr  in  4+DW  ROM data for pc_addr, valid one cycle after pc_addr is presented
acc_q  in  DW  current accumulator output (feedback)
pc_addr  out  AW  ROM address, equal to the PC
acc_clear  out  1  accumulator clear
acc_load  out  1  accumulator load
acc_inc  out  1  accumulator increment
acc_ab  out  1  accumulator mux select; 0=A (immediate), 1=B (external)
acc_a  out  DW  immediate operand, equal to IR[DW-1:0]
halted  out  1  high in HALTED state
illegal  out  1  sticky illegal-opcode flag

Behaviour:
- Reset values (asynchronous, rst_n low):
  - state=IDLE, PC=0, IR=0.
  - All acc_* controls 0; acc_a=0.
  - halted=0, illegal=0.
- Instruction format: opcode=instr[DW+3:DW], operand=instr[DW-1:0].
- Opcodes:
  - 0 NOP.
  - 1 CLR: acc_clear.
  - 2 LDA: acc_load, acc_ab=0.
  - 3 LDB: acc_load, acc_ab=1.
  - 4 INC: acc_inc.
  - 5 JMP: PC<=operand[AW-1:0].
  - 6 JZ: if acc_q==0 then PC<=operand, else PC+1.
  - 7 HALT.
  - 8-F illegal: execute as NOP and set illegal.
- States:
  - IDLE -> FETCH on start.
  - FETCH: present pc_addr. -> DECODE.
  - DECODE: IR<=instr. -> EXEC.
  - EXEC: apply controls and update PC. -> FETCH, or -> HALTED for HALT.
  - HALTED -> FETCH on start, with PC<=0 and illegal cleared. The accumulator is not cleared.
- Control timing:
  - acc_clear/acc_load/acc_inc are registered and high for exactly the one EXEC cycle. The accumulator captures on the edge that ends EXEC.
  - At most one of the three controls is high in any cycle.
  - acc_ab and acc_a are stable from DECODE+1 through the end of EXEC.
- JZ samples acc_q during EXEC; acc_q then reflects all prior instructions.
- PC update: non-jump instructions do PC+1 mod 2^AW, so PC=2^AW-1 wraps to 0. HALT leaves the PC unchanged.
- Throughput: 3 cycles per instruction; the first pc_addr is valid in the cycle after start.
- start is ignored in FETCH, DECODE and EXEC.
- illegal is set at the EXEC of an illegal opcode. It is cleared only by reset or by a start out of HALTED.
- Reset asserted mid-instruction aborts the instruction immediately. Control outputs drop asynchronously, so no partial accumulator update occurs after reset.

Decomposition:
- Package trisc_pkg: opcode localparams (OP_NOP..OP_HALT) and the state encoding (IDLE, FETCH, DECODE, EXEC, HALTED).
- One sub-module, trisc_pc: AW-bit program counter with clr, inc, and load-with-value inputs, using the same asynchronous active-low reset.

Test Plan:
- Reset check: hold rst_n=0 -> all outputs 0, state IDLE; release with start=0 -> pc_addr stays 0 and no controls pulse.
- Basic program: ROM {0x10, 0x25, 0x40, 0x70}, pulse start.
  - acc_clear pulses in cycle 3; acc_load with acc_ab=0, acc_a=5 in cycle 6; acc_inc in cycle 9.
  - halted=1 from cycle 12; pc_addr holds 3.
- JZ branch, taken vs not taken: ROM[0]=0x6A.
  - acc_q=0 -> next pc_addr=0xA.
  - acc_q=3 -> next pc_addr=1.
- Wrap-around: ROM all NOP (0x00), run 16 instructions -> pc_addr goes 0xF then 0x0; JMP 0x5F -> pc_addr=0xF.
- Illegal opcode: ROM[0]=0x9C -> no acc_* control pulses and illegal=1 after EXEC.
  - Next instruction proceeds normally.
  - HALT then start -> illegal=0, pc_addr=0.
- Reset and start interactions:
  - Assert rst_n=0 during EXEC of INC -> acc_inc drops in the same cycle and PC=0.
  - start pulsed during DECODE -> no effect on sequencing.
